// File: rtl/nfa_match_engine.sv
// ============================================================================
// Module   : nfa_match_engine
// Purpose  : Parametrised NFA regex matcher. It consumes one payload byte per
//            enabled cycle as a one-hot/multi-hot character-class bus. The
//            transition graph, the class selection and the accepting states
//            are all set by parameters. The block adds packet framing
//            (sod/eod), the offset of the first match, a saturating byte
//            counter, an optional anchored mode and a one-cycle done pulse.
// Ports    :
//   clk              in   clock
//   rst              in   synchronous active-high reset
//   sod_i            in   start of data: clears per-packet state, enters SCAN
//   eod_i            in   marks the current en byte as the last one
//   en_i             in   byte valid
//   cls_i            in   [NUM_CLASSES] class hits for the current byte
//   match_o          out  sticky match flag for the current packet
//   match_offset_o   out  [CNT_W] 0-based index of the byte completing the
//                         first match
//   done_o           out  one-cycle pulse after the eod byte is consumed
//   busy_o           out  high while scanning
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nfa_match_engine #(
   parameter int                                   NUM_STATES  = 32,
   parameter int                                   NUM_CLASSES = 16,
   parameter int                                   CLS_IDX_W   = 4,
   parameter logic [NUM_STATES*(NUM_STATES+1)-1:0] PRED_MASK   = '0,
   parameter logic [NUM_STATES*CLS_IDX_W-1:0]      CLASS_SEL   = '0,
   parameter logic [NUM_STATES-1:0]                ACCEPT_MASK = {1'b1, {(NUM_STATES-1){1'b0}}},
   parameter bit                                   ANCHORED    = 1'b0,
   parameter int                                   CNT_W       = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   sod_i,
   input  logic                   eod_i,
   input  logic                   en_i,
   input  logic [NUM_CLASSES-1:0] cls_i,
   output logic                   match_o,
   output logic [CNT_W-1:0]       match_offset_o,
   output logic                   done_o,
   output logic                   busy_o
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SCAN = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [1:0]            state_q, state_d;
   logic [NUM_STATES-1:0] s_q, s_d;
   logic                  match_q, match_d;
   logic [CNT_W-1:0]      offset_q, offset_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  done_q, done_d;

   // A byte is consumed while scanning, or in the sod cycle itself so that
   // the byte arriving with sod becomes byte 0 of the new packet.
   logic                  take;
   logic [NUM_STATES-1:0] s_cur;
   logic [CNT_W-1:0]      idx;
   logic [CNT_W-1:0]      cnt_inc;
   logic                  start;
   logic [NUM_STATES-1:0] s_next;
   logic                  hit;

   assign take    = en_i & (sod_i | (state_q == ST_SCAN));
   // sod hides the old packet's state from the byte that arrives with it.
   assign s_cur   = sod_i ? '0 : s_q;
   assign idx     = sod_i ? '0 : cnt_q;
   assign cnt_inc = (idx == CNT_MAX) ? idx : idx + CNT_W'(1);
   // The counter saturates and never wraps, so idx==0 marks only byte 0.
   assign start   = ANCHORED ? (idx == '0) : 1'b1;

   // A state is active next when its own class hits and at least one of its
   // predecessors (START or an active state) is active.
   for (genvar i = 0; i < NUM_STATES; i++) begin : g_state
      localparam int SEL = int'(CLASS_SEL[i*CLS_IDX_W +: CLS_IDX_W]);
      localparam logic [NUM_STATES:0] PRED = PRED_MASK[i*(NUM_STATES+1) +: NUM_STATES+1];
      assign s_next[i] = cls_i[SEL] & (|(PRED & {s_cur, start}));
   end

   assign hit = |(s_next & ACCEPT_MASK);

   // Class bits that no state selects are legitimately ignored.
   logic unused_cls;
   assign unused_cls = ^cls_i;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (sod_i) begin
         state_d = (en_i & eod_i) ? ST_HOLD : ST_SCAN;
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_SCAN: if (en_i & eod_i) state_d = ST_HOLD;
            ST_HOLD: state_d = ST_HOLD;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      busy_o = (state_q == ST_SCAN);
   end

   // ----------------------------------------------------------- datapath
   always_comb begin
      s_d      = s_q;
      match_d  = match_q;
      offset_d = offset_q;
      cnt_d    = cnt_q;
      if (sod_i) begin
         s_d      = '0;
         match_d  = 1'b0;
         offset_d = '0;
         cnt_d    = '0;
      end
      if (take) begin
         s_d   = s_next;
         cnt_d = cnt_inc;
         // match_d already reflects any sod clear, so only the first hit of
         // the packet records an offset.
         if (hit && !match_d) begin
            match_d  = 1'b1;
            offset_d = idx;
         end
      end
      done_d = take & eod_i;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s_q      <= '0;
         match_q  <= 1'b0;
         offset_q <= '0;
         cnt_q    <= '0;
         done_q   <= 1'b0;
      end else begin
         s_q      <= s_d;
         match_q  <= match_d;
         offset_q <= offset_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
      end
   end

   assign match_o        = match_q;
   assign match_offset_o = offset_q;
   assign done_o         = done_q;

endmodule

`default_nettype wire
